// File: rtl/disp_frame_fetch_ctrl.sv
// disp_frame_fetch_ctrl: fetches frame-memory pixels into a credit-managed
// in-order prefetch FIFO and feeds them to the panel on each DE beat.
//
// Ports:
//   i_clk, rst            clock, synchronous active-high reset
//   i_vsync, i_de         sync generator timing (rising vsync = frame start)
//   o_rd_req, o_rd_addr   read request / pixel address to frame memory
//   i_rd_ack              request accepted when o_rd_req && i_rd_ack
//   i_rd_valid, i_rd_data in-order read returns (latency >= 1)
//   o_pix_valid           i_de delayed by one cycle
//   o_pix_data            pixel for the previous DE beat (0 on underflow)
//   o_underflow           sticky: DE seen with the FIFO empty
//   o_frame_done          pulse on acceptance of the frame's last request
//
// Optional feature: define DISP_FETCH_BOTTOM_UP_EN to fetch rows
// bottom-up (BMP row order); otherwise rows are fetched top-down.

module disp_frame_fetch_ctrl #(
    parameter int HRES       = 4,
    parameter int VRES       = 4,
    parameter int DW         = 24,
    parameter int AW         = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          i_clk,
    input  logic          rst,
    input  logic          i_vsync,
    input  logic          i_de,
    output logic          o_rd_req,
    output logic [AW-1:0] o_rd_addr,
    input  logic          i_rd_ack,
    input  logic          i_rd_valid,
    input  logic [DW-1:0] i_rd_data,
    output logic          o_pix_valid,
    output logic [DW-1:0] o_pix_data,
    output logic          o_underflow,
    output logic          o_frame_done
);

    localparam int NPIX = HRES * VRES;
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = $clog2(FIFO_DEPTH + 1);

    localparam logic [AW-1:0] LAST_CNT = AW'(NPIX - 1);
    localparam logic [AW-1:0] A_ONE    = AW'(1);
    localparam logic [CW-1:0] C_ONE    = CW'(1);
    localparam logic [PW-1:0] P_ONE    = PW'(1);
    localparam logic [CW:0]   DEPTH_W  = (CW+1)'(FIFO_DEPTH);

`ifdef DISP_FETCH_BOTTOM_UP_EN
    localparam int XW = (HRES > 1) ? $clog2(HRES) : 1;
    localparam logic [AW-1:0] START_ADDR = AW'((VRES - 1) * HRES);
    localparam logic [AW-1:0] LINE_BACK  = AW'(2 * HRES - 1);
    localparam logic [XW-1:0] X_LAST     = XW'(HRES - 1);
    localparam logic [XW-1:0] X_ONE      = XW'(1);
`else
    localparam logic [AW-1:0] START_ADDR = '0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic            vsync_q, vsync_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [AW-1:0]   cnt_q, cnt_d;
`ifdef DISP_FETCH_BOTTOM_UP_EN
    logic [XW-1:0]   x_q, x_d;
`endif
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   disc_q, disc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_q, wr_d;
    logic [PW-1:0]   rd_q, rd_d;
    logic [DW-1:0]   mem_q [FIFO_DEPTH];
    logic [DW-1:0]   mem_d [FIFO_DEPTH];
    logic            pv_q, pv_d;
    logic [DW-1:0]   pd_q, pd_d;
    logic            uf_q, uf_d;

    logic            fs;
    logic [CW:0]     fill;
    logic            rd_req;
    logic            accept;
    logic            last;
    logic            drop;
    logic            push;
    logic            pop;

    assign fs     = i_vsync & ~vsync_q;
    // Reads already in flight hold their FIFO slot, so the FIFO can
    // never be overrun by returns.
    assign fill   = {1'b0, count_q} + {1'b0, outst_q};
    assign rd_req = (state_q == S_FETCH) && (fill < DEPTH_W);
    assign accept = rd_req & i_rd_ack;
    assign last   = (cnt_q == LAST_CNT);
    assign drop   = i_rd_valid && (disc_q != '0);
    assign push   = i_rd_valid && (disc_q == '0) && !fs;
    assign pop    = i_de && (count_q != '0);

    // Request sequencing and address generation
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
`ifdef DISP_FETCH_BOTTOM_UP_EN
        x_d     = x_q;
`endif
        unique case (state_q)
            S_IDLE: ;
            S_FETCH: begin
                if (accept) begin
                    cnt_d = cnt_q + A_ONE;
`ifdef DISP_FETCH_BOTTOM_UP_EN
                    if (x_q == X_LAST) begin
                        addr_d = addr_q - LINE_BACK;
                        x_d    = '0;
                    end else begin
                        addr_d = addr_q + A_ONE;
                        x_d    = x_q + X_ONE;
                    end
`else
                    addr_d = addr_q + A_ONE;
`endif
                    if (last) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: ;
            default: state_d = S_IDLE;
        endcase
        if (fs) begin
            state_d = S_FETCH;
            addr_d  = START_ADDR;
            cnt_d   = '0;
`ifdef DISP_FETCH_BOTTOM_UP_EN
            x_d     = '0;
`endif
        end
    end

    // Outstanding reads and the discard budget for stale returns
    always_comb begin
        vsync_d = i_vsync;
        outst_d = outst_q;
        disc_d  = disc_q;
        if (accept && !i_rd_valid) begin
            outst_d = outst_q + C_ONE;
        end else if (!accept && i_rd_valid) begin
            outst_d = outst_q - C_ONE;
        end
        if (drop) begin
            disc_d = disc_q - C_ONE;
        end
        // Everything still in flight after this cycle belongs to the old
        // frame, including a request accepted on the frame-start cycle
        // itself (it carries an old-frame address).
        if (fs) begin
            disc_d = outst_d;
        end
    end

    // Prefetch FIFO
    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (push) begin
            mem_d[wr_q] = i_rd_data;
            wr_d        = wr_q + P_ONE;
        end
        if (pop) begin
            rd_d = rd_q + P_ONE;
        end
        if (push && !pop) begin
            count_d = count_q + C_ONE;
        end else if (pop && !push) begin
            count_d = count_q - C_ONE;
        end
        if (fs) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end
    end

    // Pixel output stage
    always_comb begin
        pv_d = i_de;
        pd_d = pd_q;
        uf_d = uf_q;
        if (i_de) begin
            if (count_q != '0) begin
                pd_d = mem_q[rd_q];
            end else begin
                pd_d = '0;
                uf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            vsync_q <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
`ifdef DISP_FETCH_BOTTOM_UP_EN
            x_q     <= '0;
`endif
            outst_q <= '0;
            disc_q  <= '0;
            count_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            pv_q    <= 1'b0;
            pd_q    <= '0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            vsync_q <= vsync_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
`ifdef DISP_FETCH_BOTTOM_UP_EN
            x_q     <= x_d;
`endif
            outst_q <= outst_d;
            disc_q  <= disc_d;
            count_q <= count_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            mem_q   <= mem_d;
            pv_q    <= pv_d;
            pd_q    <= pd_d;
            uf_q    <= uf_d;
        end
    end

    assign o_rd_req     = rd_req;
    assign o_rd_addr    = addr_q;
    assign o_frame_done = accept & last;
    assign o_pix_valid  = pv_q;
    assign o_pix_data   = pd_q;
    assign o_underflow  = uf_q;

endmodule
